// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module : spi_shift_engine
// Brief  : FIFO-fed SPI serialiser/deserialiser timed by baud-edge ticks.
//          Define SPI_LOOPBACK_EN to add the internal tx->rx loopback input.
// Rev    : 1.0
// ============================================================================
module spi_shift_engine #(
    parameter int DATA_W        = 32,
    parameter int CS_HOLD_TICKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              baud_in,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [4:0]        word_size,
    input  logic [1:0]        cs_select,
    input  logic              cs_auto,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_pop,
    input  logic              rx_full,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_push,
    output logic              rxfo_set,
    output logic              busy,
    input  logic              rx,
    output logic              tx,
    output logic              clk_out,
    output logic              cs_0,
    output logic              cs_1,
    output logic              cs_2,
    output logic              cs_3
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              baud1_q, baud2_q;
    logic [6:0]        cnt_q, cnt_d;
    logic [3:0]        hold_q, hold_d;
    logic [4:0]        idx_q, idx_d;
    logic [1:0]        sel_q, sel_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_W-1:0] data_q, data_d, rxsh_q, rxsh_d, rx_data_q, rx_data_d;
    logic              tx_q, tx_d, sck_q, sck_d;
    logic [3:0]        cs_q, cs_d;
    logic              push_q, push_d, rxfo_q, rxfo_d;

    logic              w_tick, w_lead, w_smp;
    logic [4:0]        w_idx_m1;

    assign w_tick   = baud1_q ^ baud2_q;
    // The frame spans an even tick count, so an even remaining count marks a leading edge.
    assign w_lead   = ~cnt_q[0];
    assign w_idx_m1 = idx_q - 5'd1;
`ifdef SPI_LOOPBACK_EN
    assign w_smp    = loopback ? tx_q : rx;
`else
    assign w_smp    = rx;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        data_d    = data_q;
        rxsh_d    = rxsh_q;
        rx_data_d = rx_data_q;
        tx_d      = tx_q;
        sck_d     = sck_q;
        cs_d      = cs_q;
        push_d    = 1'b0;
        rxfo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sck_d = cpol;
                cs_d  = 4'hF;
                if (!tx_empty)
                    state_d = LOAD;
            end
            LOAD: begin
                data_d  = tx_data;
                cpol_d  = cpol;
                cpha_d  = cpha;
                sel_d   = cs_select;
                idx_d   = word_size;
                rxsh_d  = '0;
                sck_d   = cpol;
                cs_d    = ~(4'b0001 << cs_select);
                cnt_d   = {1'b0, word_size, 1'b0} + 7'd2;
                if (!cpha)
                    tx_d = tx_data[word_size];
                state_d = SHIFT;
            end
            SHIFT: begin
                if (w_tick) begin
                    sck_d = ~sck_q;
                    cnt_d = cnt_q - 7'd1;
                    if (w_lead) begin
                        if (cpha_q) begin
                            tx_d  = data_q[idx_q];
                            idx_d = w_idx_m1;
                        end else begin
                            rxsh_d = {rxsh_q[DATA_W-2:0], w_smp};
                        end
                    end else begin
                        if (cpha_q) begin
                            rxsh_d = {rxsh_q[DATA_W-2:0], w_smp};
                        end else if (cnt_q != 7'd1) begin
                            tx_d  = data_q[w_idx_m1];
                            idx_d = w_idx_m1;
                        end
                    end
                    if (cnt_q == 7'd1) begin
                        sck_d   = cpol_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (rx_full) begin
                    rxfo_d = 1'b1;
                end else begin
                    push_d    = 1'b1;
                    rx_data_d = rxsh_q;
                end
                hold_d  = 4'(CS_HOLD_TICKS);
                state_d = HOLD;
            end
            HOLD: begin
                if (w_tick) begin
                    hold_d = hold_q - 4'd1;
                    if (hold_q == 4'd1) begin
                        // Back-to-back frames keep CS low only if the same slave is still selected.
                        if (!cs_auto && !tx_empty && (cs_select == sel_q)) begin
                            state_d = LOAD;
                        end else begin
                            cs_d    = 4'hF;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d   = IDLE;
            cs_d      = 4'hF;
            sck_d     = cpol;
            tx_d      = 1'b0;
            push_d    = 1'b0;
            rxfo_d    = 1'b0;
            rx_data_d = rx_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud1_q   <= 1'b0;
            baud2_q   <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            data_q    <= '0;
            rxsh_q    <= '0;
            rx_data_q <= '0;
            tx_q      <= 1'b0;
            sck_q     <= 1'b0;
            cs_q      <= 4'hF;
            push_q    <= 1'b0;
            rxfo_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud1_q   <= baud_in;
            baud2_q   <= baud1_q;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            data_q    <= data_d;
            rxsh_q    <= rxsh_d;
            rx_data_q <= rx_data_d;
            tx_q      <= tx_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            push_q    <= push_d;
            rxfo_q    <= rxfo_d;
        end
    end

    assign tx_pop   = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign rx_push  = push_q;
    assign rxfo_set = rxfo_q;
    assign rx_data  = rx_data_q;
    assign tx       = tx_q;
    assign clk_out  = sck_q;
    assign cs_0     = cs_q[0];
    assign cs_1     = cs_q[1];
    assign cs_2     = cs_q[2];
    assign cs_3     = cs_q[3];

endmodule
`default_nettype wire
